// File: rtl/encoder_if.sv
// encoder_if -- handshake bundle for encoder_stage.
//
// Input side:  in_valid / in_ready / in_select, plus in_clear for the error counter.
// Output side: out_valid / out_ready / out_address / out_error / out_error_count.
//
// Modports:
//   slave  -- the encoder stage itself
//   master -- whatever drives the select vectors and consumes the addresses
interface encoder_if #(
  parameter int NUM_INPUT = 5
);
  localparam int ADDR_W = $clog2(NUM_INPUT);

  logic                 in_valid;
  logic                 in_ready;
  logic [NUM_INPUT-1:0] in_select;
  logic                 in_clear;
  logic                 out_valid;
  logic                 out_ready;
  logic [ADDR_W-1:0]    out_address;
  logic                 out_error;
  logic [7:0]           out_error_count;

  modport slave (
    input  in_valid, in_select, in_clear, out_ready,
    output in_ready, out_valid, out_address, out_error, out_error_count
  );

  modport master (
    output in_valid, in_select, in_clear, out_ready,
    input  in_ready, out_valid, out_address, out_error, out_error_count
  );
endinterface

// File: rtl/encoder_stage.sv
// encoder_stage -- registered one-hot to binary encoder with valid/ready on both sides.
//
// Converts an N-bit select vector into a binary address. It also flags illegal
// vectors and keeps a saturating 8-bit count of the illegal words it accepts.
// The stage is one register deep. in_ready is high when the output register is
// empty or is being drained in the same cycle.
//
// Ports:
//   clk    -- rising-edge clock
//   rst_n  -- asynchronous active-low reset
//   bus    -- encoder_if.slave
//             (in_valid/in_ready/in_select/in_clear,
//              out_valid/out_ready/out_address/out_error/out_error_count)
//
// Build option:
//   ENCODER_PRIORITY_EN -- when defined, a multi-hot vector encodes to its lowest
//                          set index without error. Only all-zero is illegal.
//                          When undefined, any vector that is not one-hot is
//                          illegal and encodes to address 0.
module encoder_stage #(
  parameter int NUM_INPUT = 5
) (
  input  logic      clk,
  input  logic      rst_n,
  encoder_if.slave  bus
);
  localparam int ADDR_W = $clog2(NUM_INPUT);

  // Returns {error, address} for one select vector.
  function automatic logic [ADDR_W:0] encode(input logic [NUM_INPUT-1:0] sel);
    logic [ADDR_W-1:0] addr;
    logic              err;
`ifdef ENCODER_PRIORITY_EN
    addr = '0;
    // Scan from the top down so the lowest set bit is the last one written.
    for (int k = NUM_INPUT - 1; k >= 0; k--) begin
      if (sel[k]) addr = ADDR_W'(k);
    end
    err = (sel == '0);
`else
    logic seen;
    logic multi;
    addr  = '0;
    seen  = 1'b0;
    multi = 1'b0;
    for (int k = 0; k < NUM_INPUT; k++) begin
      if (sel[k]) begin
        if (seen) multi = 1'b1;
        seen = 1'b1;
        addr = ADDR_W'(k);
      end
    end
    err = !seen || multi;
    if (err) addr = '0;
`endif
    return {err, addr};
  endfunction

  // Adds one to the counter. The value holds at 255 instead of wrapping to 0.
  function automatic logic [7:0] sat_inc(input logic [7:0] cnt);
    return (cnt == 8'hFF) ? cnt : cnt + 8'd1;
  endfunction

  logic [ADDR_W-1:0] addr_p0;
  logic              err_p0;
  logic              vld_p0;
  logic [7:0]        cnt_p0;
  logic [ADDR_W:0]   enc;
  logic              accept;

  assign enc      = encode(bus.in_select);
  assign accept   = bus.in_valid && bus.in_ready;
  // Depends only on the register state and out_ready, never on in_valid.
  assign bus.in_ready = !vld_p0 || bus.out_ready;

  // ---- stage p0: output register and error counter ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0  <= 1'b0;
      addr_p0 <= '0;
      err_p0  <= 1'b0;
      cnt_p0  <= 8'd0;
    end else begin
      if (accept) begin
        vld_p0  <= 1'b1;
        addr_p0 <= enc[ADDR_W-1:0];
        err_p0  <= enc[ADDR_W];
      end else if (bus.out_ready) begin
        // Drain empties the register. The data is kept for observability.
        vld_p0 <= 1'b0;
      end

      if (bus.in_clear) begin
        cnt_p0 <= 8'd0;
      end else if (accept && enc[ADDR_W]) begin
        cnt_p0 <= sat_inc(cnt_p0);
      end
    end
  end

  assign bus.out_valid       = vld_p0;
  assign bus.out_address     = addr_p0;
  assign bus.out_error       = err_p0;
  assign bus.out_error_count = cnt_p0;
endmodule

// File: tb/tb_encoder_stage.sv
// tb_encoder_stage -- bench for encoder_stage (NUM_INPUT = 5).
// The driver issues directed and random words and pushes the expected
// {error, address} of each accepted word into a queue. A monitor pops the
// queue whenever the DUT hands a result to the consumer. Handshake state and
// the error count are followed by a cycle-level model held in the driver.
module tb_encoder_stage;
  localparam int N = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  encoder_if #(.NUM_INPUT(N)) bus();

  encoder_stage #(.NUM_INPUT(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  logic [3:0] sb[$];         // {error, address[2:0]}
  logic       m_occ = 1'b0;
  logic [2:0] m_addr = 3'd0;
  logic       m_err = 1'b0;
  int         m_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encode based on the population count and the position of the lowest set bit.
  function automatic void ref_enc(input logic [N-1:0] s, output logic [2:0] a, output logic e);
    int n;
    n = $countones(s);
`ifdef ENCODER_PRIORITY_EN
    if (n == 0) begin a = 3'd0; e = 1'b1; end
    else        begin a = 3'($clog2(s & (~s + 5'd1))); e = 1'b0; end
`else
    if (n == 1) begin a = 3'($clog2(s)); e = 1'b0; end
    else        begin a = 3'd0;          e = 1'b1; end
`endif
  endfunction

  // Called at posedge+1. It applies the inputs, checks the state that is
  // visible now, advances the model, and returns at the next posedge+1.
  task automatic cycle(input logic v, input logic [N-1:0] s, input logic r, input logic c);
    logic [2:0] a;
    logic       e;
    logic       acc;
    bus.in_valid  = v;
    bus.in_select = s;
    bus.out_ready = r;
    bus.in_clear  = c;
    #1;
    chk("in_ready", 32'(bus.in_ready), 32'(!m_occ || r));
    chk("out_valid", 32'(bus.out_valid), 32'(m_occ));
    chk("err_count", 32'(bus.out_error_count), 32'(m_cnt));
    if (m_occ) begin
      chk("addr_now", 32'(bus.out_address), 32'(m_addr));
      chk("err_now", 32'(bus.out_error), 32'(m_err));
    end
    acc = v && (!m_occ || r);
    ref_enc(s, a, e);
    if (acc) begin
      sb.push_back({e, a});
      m_occ = 1'b1; m_addr = a; m_err = e;
    end else if (r) begin
      m_occ = 1'b0;
    end
    if (c) m_cnt = 0;
    else if (acc && e && m_cnt < 255) m_cnt++;
    @(posedge clk); #1;
  endtask

  // Monitor: a result is consumed at the next edge when valid && ready.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        chk("sb_empty_pop", 32'(bus.out_valid), 32'd0);
      end else begin
        logic [3:0] x;
        x = sb.pop_front();
        chk("sb_addr", 32'(bus.out_address), 32'(x[2:0]));
        chk("sb_err", 32'(bus.out_error), 32'(x[3]));
      end
    end
  end

  initial begin
    bus.in_valid = 1'b0; bus.in_select = '0; bus.out_ready = 1'b0; bus.in_clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_addr", 32'(bus.out_address), 32'd0);
    chk("rst_err", 32'(bus.out_error), 32'd0);
    chk("rst_count", 32'(bus.out_error_count), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // One-hot sweep
    for (int k = 0; k < N; k++) cycle(1'b1, 5'(1 << k), 1'b1, 1'b0);
    cycle(1'b0, 5'b0, 1'b1, 1'b0);

    // Zero vector, then a clear together with another zero accept
    cycle(1'b1, 5'b00000, 1'b1, 1'b0);
    cycle(1'b1, 5'b00000, 1'b1, 1'b1);
    cycle(1'b0, 5'b0, 1'b1, 1'b0);

    // Multi-hot
    cycle(1'b1, 5'b01010, 1'b1, 1'b0);
    cycle(1'b0, 5'b0, 1'b1, 1'b0);

    // Backpressure
    cycle(1'b1, 5'b00100, 1'b1, 1'b0);
    repeat (3) cycle(1'b1, 5'b01000, 1'b0, 1'b0);
    cycle(1'b1, 5'b01000, 1'b1, 1'b0);
    cycle(1'b0, 5'b0, 1'b1, 1'b0);

    // Saturation
    repeat (260) cycle(1'b1, 5'b00000, 1'b1, 1'b0);
    cycle(1'b0, 5'b0, 1'b1, 1'b0);
    chk("sat_count", 32'(bus.out_error_count), 32'd255);

    // Randomized traffic
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 3) != 0), 5'($urandom), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 29) == 0));

    // Reset with a pending result and count = 7
    cycle(1'b0, 5'b0, 1'b1, 1'b1);
    repeat (7) cycle(1'b1, 5'b00000, 1'b1, 1'b0);
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    #2;
    chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    chk("pre_rst_count", 32'(bus.out_error_count), 32'd7);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("async_rst_count", 32'(bus.out_error_count), 32'd0);
    sb.delete();
    m_occ = 1'b0; m_cnt = 0; m_addr = 3'd0; m_err = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    cycle(1'b0, 5'b0, 1'b0, 1'b0);
    cycle(1'b1, 5'b10000, 1'b1, 1'b0);
    repeat (2) cycle(1'b0, 5'b0, 1'b1, 1'b0);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
